control_seq: RTL
================

CONTROL_SEQ -- requirements
Module: control_seq

Interface
REQ-001 SHALL have parameter NREG, default 6, number of general registers R[0..NREG-1]; legal range 1..6.
REQ-002 SHALL have parameter MEM_LAT, default 2, cycles a memory read/write-back is held; legal range 1..8.
REQ-003 SHALL have parameter OPW, default 6, opcode field width; opcode = instruction[OPW-1:0], rsel = instruction[OPW+3:OPW].
REQ-004 SHALL have ports, clock first:
  clock  in  1  sole clock, all state updates on rising edge
  reset  in  1  synchronous, active-high reset
  start  in  1  leave IDLE and begin fetching
  hold  in  1  stall: freeze state and counter
  instruction  in  16  current IR contents
  z  in  1  ALU zero flag
  alu_op  out  3  ALU operation
  read_en  out  4  bus-source select code
  write_en  out  16  one-hot-per-target register load enables
  inc_en  out  16  register increment enables
  busy  out  1  high in every state except IDLE and END
  end_process  out  1  registered, program finished
  illegal_op  out  1  registered one-cycle pulse, undefined opcode or rsel>=NREG
REQ-005 SHALL use only one clock; reset is synchronous and active-high.

Function
REQ-006 Bus map SHALL be: read_en 2=DAR, 5=AC, 6+k=R[k], 12=data mem, 13=instr mem, 0=none; write_en bit1 PC, bit2 DAR, bit4 IR, bit5 AC, bit(6+k) R[k], bit12 mem write, bits15:14 ALU result+flags; inc_en bit1 PC, bit2 AC, bit3 DAR, bit(4+k) R[k].
REQ-007 alu_op/read_en/write_en/inc_en SHALL be Moore outputs decoded from state and latency counter only; unlisted fields are 0.
REQ-008 IDLE: all outputs 0; start=1 -> FETCH next cycle.
REQ-009 FETCH: read_en=13, write_en bit4, MEM_LAT cycles, then DECODE: read_en=13, 1 cycle, branch on opcode.
REQ-010 Opcodes: 0 NOP, 1 LOADAC, 2 MOVACR, 3 MOVRAC, 4 STAC, 5 ADD, 6 SUB, 7 LSHIFT, 8 RSHIFT, 9 INCAC, 10 INCR, 11 LOADIM, 12 JUMP, 13 JUMPZ, 14 JUMPNZ, 15 END; all others illegal.
REQ-011 NOP: 1 cycle inc PC. MOVACR: 1 cycle read 5, write bit(6+rsel), inc PC. MOVRAC: 1 cycle read 6+rsel, write bit5, inc PC.
REQ-012 LOADAC: MEM_LAT cycles read 5 write bit2; then MEM_LAT cycles read 12 write bit5, inc PC on last cycle only.
REQ-013 STAC: 1 cycle read 5; 1 cycle read 5 write bit12; 1 cycle read 5 inc PC.
REQ-014 ADD/SUB/LSHIFT/RSHIFT: alu_op 1/2/3/4 for 2 cycles; cycle 2 writes bits15:14 and inc PC.
REQ-015 INCAC: 1 cycle inc bits 2,1. INCR: 1 cycle inc bits (4+rsel),1.
REQ-016 LOADIM: 1 cycle inc PC; MEM_LAT cycles read 13, write bit5 and inc PC on last cycle.
REQ-017 JUMP: 1 cycle inc PC; MEM_LAT cycles read 13 write bit1; -> FETCH.
REQ-018 JUMPZ/JUMPNZ: z sampled in the first (inc PC) cycle; taken (z=1 / z=0) -> JUMP target sequence; not taken -> 1 cycle inc PC (skip operand) -> FETCH.
REQ-019 Every other sequence SHALL return to FETCH.
REQ-020 Illegal opcode, or rsel>=NREG on MOVACR/MOVRAC/INCR: execute as NOP; illegal_op high exactly the following cycle.
REQ-021 END: read_en=12, held until reset; start ignored; end_process=1 from the cycle after entering END.
REQ-022 hold=1: state and counter unchanged, write_en=inc_en=0, read_en/alu_op retained; resumes identically on release; hold ignored in IDLE and END.
REQ-023 Latency counter SHALL be 3 bits, reload 0 on each state entry, never wrap past MEM_LAT-1.

Reset
REQ-024 reset=1 at any edge, including mid-sequence or under hold, SHALL force IDLE, counter 0, end_process 0, illegal_op 0; all outputs 0 the following cycle.
REQ-025 reset SHALL take priority over start and hold.

Verification
REQ-026 MEM_LAT=2, start, opcode 5: write_en bit4 2 cycles, DECODE, alu_op=1 2 cycles, write_en=0xC000 plus inc_en=0x0002 on 2nd.
REQ-027 MOVACR rsel=3: write_en=0x0200, read_en=5, inc_en=0x0002 single cycle; rsel=6 with NREG=6 -> NOP, illegal_op 1 cycle.
REQ-028 JUMPZ, z=0: inc PC twice, no write_en bit1; z=1: inc PC, then write_en=0x0002 for MEM_LAT cycles, then FETCH.
REQ-029 hold=1 for 3 cycles mid-LOADAC data phase: write_en=0, state frozen; release completes remaining cycles, inc PC once.
REQ-030 opcode 15: end_process=1 next cycle, busy=0, start ignored; reset -> IDLE, end_process=0.

Source files
------------

// File: rtl/control_seq.sv
// control_seq: multi-cycle control sequencer for a small accumulator datapath.
// Steps fetch/decode/execute and drives bus-source, load and increment enables.
module control_seq #(
    parameter int NREG    = 6,
    parameter int MEM_LAT = 2,
    parameter int OPW     = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        hold,
    input  logic [15:0] instruction,
    input  logic        z,
    output logic [2:0]  alu_op,
    output logic [3:0]  read_en,
    output logic [15:0] write_en,
    output logic [15:0] inc_en,
    output logic        busy,
    output logic        end_process,
    output logic        illegal_op
);

    typedef enum logic [4:0] {
        S_IDLE, S_FETCH, S_DECODE, S_NOP, S_MOVACR, S_MOVRAC,
        S_LDA_ADDR, S_LDA_DATA, S_STAC1, S_STAC2, S_STAC3,
        S_ALU1, S_ALU2, S_INCAC, S_INCR, S_LDI1, S_LDI2,
        S_JMP1, S_JMP2, S_JZ1, S_JNZ1, S_JSKIP, S_END
    } state_t;

    localparam logic [2:0] LAST = 3'(MEM_LAT - 1);

    state_t      state_r, state_s;
    logic [2:0]  cnt_r, cnt_s;
    logic [3:0]  rsel_r, rsel_s;
    logic [2:0]  alu_r, alu_s;
    logic        ill_s;
    logic        freeze_s;
    logic        last_s;
    logic        nlast_s;
    logic [15:0] opc_s;
    logic [3:0]  rs_s;
    logic        rs_ok_s;
    logic        unused_hi_s;

    logic [2:0]  alu_d_s;
    logic [3:0]  rd_d_s;
    logic [15:0] wen_d_s;
    logic [15:0] inc_d_s;

    logic [2:0]  alu_op_r;
    logic [3:0]  read_en_r;
    logic [15:0] write_en_r;
    logic [15:0] inc_en_r;
    logic        busy_r;
    logic        end_r;
    logic        ill_r;

    assign opc_s       = 16'(instruction[OPW-1:0]);
    assign rs_s        = instruction[OPW+3:OPW];
    assign rs_ok_s     = (int'(rs_s) < NREG);
    assign unused_hi_s = &{1'b0, instruction[15:OPW+4]};
    assign freeze_s    = hold && (state_r != S_IDLE) && (state_r != S_END);
    assign last_s      = (cnt_r == LAST);
    assign nlast_s     = (cnt_s == LAST);

    // Next state, latency counter and latched instruction fields.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        rsel_s  = rsel_r;
        alu_s   = alu_r;
        ill_s   = 1'b0;
        if (freeze_s) begin
            state_s = state_r;
        end else begin
            cnt_s = 3'd0;
            case (state_r)
                S_IDLE:   state_s = start ? S_FETCH : S_IDLE;
                S_FETCH: begin
                    if (last_s) begin
                        state_s = S_DECODE;
                    end else begin
                        cnt_s = cnt_r + 3'd1;
                    end
                end
                S_DECODE: begin
                    rsel_s = rs_s;
                    case (opc_s)
                        16'd0:  state_s = S_NOP;
                        16'd1:  state_s = S_LDA_ADDR;
                        16'd2: begin
                            state_s = rs_ok_s ? S_MOVACR : S_NOP;
                            ill_s   = !rs_ok_s;
                        end
                        16'd3: begin
                            state_s = rs_ok_s ? S_MOVRAC : S_NOP;
                            ill_s   = !rs_ok_s;
                        end
                        16'd4:  state_s = S_STAC1;
                        16'd5, 16'd6, 16'd7, 16'd8: begin
                            state_s = S_ALU1;
                            alu_s   = opc_s[2:0] - 3'd4;
                        end
                        16'd9:  state_s = S_INCAC;
                        16'd10: begin
                            state_s = rs_ok_s ? S_INCR : S_NOP;
                            ill_s   = !rs_ok_s;
                        end
                        16'd11: state_s = S_LDI1;
                        16'd12: state_s = S_JMP1;
                        16'd13: state_s = S_JZ1;
                        16'd14: state_s = S_JNZ1;
                        16'd15: state_s = S_END;
                        default: begin
                            state_s = S_NOP;
                            ill_s   = 1'b1;
                        end
                    endcase
                end
                S_LDA_ADDR: begin
                    if (last_s) begin
                        state_s = S_LDA_DATA;
                    end else begin
                        cnt_s = cnt_r + 3'd1;
                    end
                end
                S_LDA_DATA, S_LDI2, S_JMP2: begin
                    if (last_s) begin
                        state_s = S_FETCH;
                    end else begin
                        cnt_s = cnt_r + 3'd1;
                    end
                end
                S_STAC1: state_s = S_STAC2;
                S_STAC2: state_s = S_STAC3;
                S_ALU1:  state_s = S_ALU2;
                S_LDI1:  state_s = S_LDI2;
                S_JMP1:  state_s = S_JMP2;
                S_JZ1:   state_s = z ? S_JMP2 : S_JSKIP;
                S_JNZ1:  state_s = z ? S_JSKIP : S_JMP2;
                S_END:   state_s = S_END;
                default: state_s = S_FETCH;
            endcase
        end
    end

    // Moore output decode of the upcoming state, registered below.
    always_comb begin
        alu_d_s = 3'd0;
        rd_d_s  = 4'd0;
        wen_d_s = 16'h0000;
        inc_d_s = 16'h0000;
        case (state_s)
            S_FETCH: begin
                rd_d_s  = 4'd13;
                wen_d_s = 16'h0010;
            end
            S_DECODE: rd_d_s = 4'd13;
            S_NOP, S_LDI1, S_JMP1, S_JZ1, S_JNZ1, S_JSKIP: inc_d_s = 16'h0002;
            S_MOVACR: begin
                rd_d_s  = 4'd5;
                wen_d_s = 16'h0001 << (4'd6 + rsel_s);
                inc_d_s = 16'h0002;
            end
            S_MOVRAC: begin
                rd_d_s  = 4'd6 + rsel_s;
                wen_d_s = 16'h0020;
                inc_d_s = 16'h0002;
            end
            S_LDA_ADDR: begin
                rd_d_s  = 4'd5;
                wen_d_s = 16'h0004;
            end
            S_LDA_DATA: begin
                rd_d_s  = 4'd12;
                wen_d_s = 16'h0020;
                inc_d_s = nlast_s ? 16'h0002 : 16'h0000;
            end
            S_STAC1: rd_d_s = 4'd5;
            S_STAC2: begin
                rd_d_s  = 4'd5;
                wen_d_s = 16'h1000;
            end
            S_STAC3: begin
                rd_d_s  = 4'd5;
                inc_d_s = 16'h0002;
            end
            S_ALU1: alu_d_s = alu_s;
            S_ALU2: begin
                alu_d_s = alu_s;
                wen_d_s = 16'hC000;
                inc_d_s = 16'h0002;
            end
            S_INCAC: inc_d_s = 16'h0006;
            S_INCR:  inc_d_s = (16'h0001 << (4'd4 + rsel_s)) | 16'h0002;
            S_LDI2: begin
                rd_d_s  = 4'd13;
                wen_d_s = nlast_s ? 16'h0020 : 16'h0000;
                inc_d_s = nlast_s ? 16'h0002 : 16'h0000;
            end
            S_JMP2: begin
                rd_d_s  = 4'd13;
                wen_d_s = 16'h0002;
            end
            S_END:   rd_d_s = 4'd12;
            default: rd_d_s = 4'd0;
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= S_IDLE;
            cnt_r      <= 3'd0;
            rsel_r     <= 4'd0;
            alu_r      <= 3'd0;
            alu_op_r   <= 3'd0;
            read_en_r  <= 4'd0;
            write_en_r <= 16'h0000;
            inc_en_r   <= 16'h0000;
            busy_r     <= 1'b0;
            end_r      <= 1'b0;
            ill_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            rsel_r     <= rsel_s;
            alu_r      <= alu_s;
            alu_op_r   <= alu_d_s;
            read_en_r  <= rd_d_s;
            write_en_r <= wen_d_s;
            inc_en_r   <= inc_d_s;
            busy_r     <= (state_s != S_IDLE) && (state_s != S_END);
            end_r      <= (state_r == S_END);
            ill_r      <= ill_s;
        end
    end

    // A held cycle performs no register loads or increments.
    assign alu_op      = alu_op_r;
    assign read_en     = read_en_r;
    assign write_en    = hold ? 16'h0000 : write_en_r;
    assign inc_en      = hold ? 16'h0000 : inc_en_r;
    assign busy        = busy_r;
    assign end_process = end_r;
    assign illegal_op  = ill_r;

endmodule
